// File: rtl/nn_ctrl_pkg.sv
// Shared types and defaults for the network sequencer slice.
//   seq_state_e       : sequencer FSM states
//   DefaultTimeout... : default per-layer watchdog limit
//   DefaultLatency... : default latency counter width
//   clog2_min1()      : $clog2 clamped to a minimum width of 1
package nn_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StRun,
      StDone,
      StError
   } seq_state_e;

   localparam int unsigned DefaultTimeoutCycles = 1024;
   localparam int unsigned DefaultLatencyWidth  = 16;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-layer watchdog counter.
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset
//   clear_i    : restart the count at zero
//   enable_i   : layer is running, count this cycle
//   expired_o  : this enabled cycle is the last one allowed (TimeoutCycles enabled cycles seen)
module seq_watchdog
   import nn_ctrl_pkg::*;
#(
   parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CntWidth = clog2_min1(TimeoutCycles);
   localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TimeoutCycles - 1);

   logic [CntWidth-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != LastCnt)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Combinational so the sequencer can leave RUN at the end of the limit cycle; done has priority
   // in the caller.
   assign expired_o = enable_i && (count_q == LastCnt);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/network_sequencer.sv
// Sequences one inference through numLayers chained layers: accept input, then clear / enable /
// capture each layer in turn, then hold the result until consumed. Per-layer watchdog drops into
// a sticky ERROR state; a saturating counter measures accept-to-result latency.
//   inValid/inReady        : input vector handshake; inCapture pulses on accept
//   layerClear/Capture     : one-hot pulses for layer k
//   layerEnable/layerDone  : one-hot run level and per-layer completion
//   resultValid/Ready      : result handshake
//   busy, error, errorLayer, errClear : status and error recovery
//   latency                : cycles from accept to result of the last completed inference
module network_sequencer
   import nn_ctrl_pkg::*;
#(
   parameter int unsigned numLayers     = 2,
   parameter int unsigned timeoutCycles = DefaultTimeoutCycles,
   parameter int unsigned latencyWidth  = DefaultLatencyWidth,
   localparam int unsigned IdxWidth     = clog2_min1(numLayers)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    inValid,
   output logic                    inReady,
   output logic                    inCapture,
   output logic [numLayers-1:0]    layerClear,
   output logic [numLayers-1:0]    layerEnable,
   input  logic [numLayers-1:0]    layerDone,
   output logic [numLayers-1:0]    layerCapture,
   output logic                    resultValid,
   input  logic                    resultReady,
   output logic                    busy,
   output logic                    error,
   output logic [IdxWidth-1:0]     errorLayer,
   input  logic                    errClear,
   output logic [latencyWidth-1:0] latency
);

   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(numLayers - 1);

   function automatic logic [numLayers-1:0] onehot(input logic [IdxWidth-1:0] idx);
      logic [numLayers-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   seq_state_e              state_q, state_d;
   logic [IdxWidth-1:0]     k_q, k_d;
   logic [latencyWidth-1:0] lat_cnt_q, lat_cnt_d, lat_cnt_inc;
   logic [latencyWidth-1:0] latency_q, latency_d;
   logic                    error_q, error_d;
   logic [IdxWidth-1:0]     error_layer_q, error_layer_d;
   logic                    in_ready_q, in_ready_d;
   logic                    in_capture_q, in_capture_d;
   logic [numLayers-1:0]    clear_q, clear_d;
   logic [numLayers-1:0]    enable_q, enable_d;
   logic [numLayers-1:0]    capture_q, capture_d;
   logic                    result_valid_q, result_valid_d;
   logic                    busy_q, busy_d;
   logic                    wd_clear, wd_expired;

   seq_watchdog #(
      .TimeoutCycles(timeoutCycles)
   ) u_watchdog (
      .clk_i    (clk),
      .rst_i    (reset),
      .clear_i  (wd_clear),
      .enable_i (state_q == StRun),
      .expired_o(wd_expired)
   );

   assign lat_cnt_inc = (lat_cnt_q == {latencyWidth{1'b1}}) ? lat_cnt_q : lat_cnt_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      lat_cnt_d     = lat_cnt_q;
      latency_d     = latency_q;
      error_d       = error_q;
      error_layer_d = error_layer_q;
      in_capture_d  = 1'b0;
      clear_d       = '0;
      capture_d     = '0;
      wd_clear      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (inValid) begin
               state_d      = StClear;
               k_d          = '0;
               in_capture_d = 1'b1;
               clear_d      = onehot('0);
               lat_cnt_d    = latencyWidth'(1);
            end
         end
         StClear: begin
            state_d   = StRun;
            wd_clear  = 1'b1;
            lat_cnt_d = lat_cnt_inc;
         end
         StRun: begin
            lat_cnt_d = lat_cnt_inc;
            if (layerDone[k_q]) begin
               capture_d = onehot(k_q);
               if (k_q == LastIdx) begin
                  state_d   = StDone;
                  latency_d = lat_cnt_q;
               end else begin
                  state_d = StClear;
                  k_d     = k_q + 1'b1;
                  clear_d = onehot(k_q + 1'b1);
               end
            end else if (wd_expired) begin
               state_d       = StError;
               error_d       = 1'b1;
               error_layer_d = k_q;
            end
         end
         StDone: begin
            if (resultReady) begin
               state_d = StIdle;
            end
         end
         StError: begin
            if (errClear) begin
               state_d = StIdle;
               error_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      // Level outputs are registered copies of the next state.
      in_ready_d     = (state_d == StIdle);
      result_valid_d = (state_d == StDone);
      busy_d         = (state_d == StClear) || (state_d == StRun) || (state_d == StDone);
      enable_d       = (state_d == StRun) ? onehot(k_d) : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         k_q            <= '0;
         lat_cnt_q      <= '0;
         latency_q      <= '0;
         error_q        <= 1'b0;
         error_layer_q  <= '0;
         in_ready_q     <= 1'b1;
         in_capture_q   <= 1'b0;
         clear_q        <= '0;
         enable_q       <= '0;
         capture_q      <= '0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         k_q            <= k_d;
         lat_cnt_q      <= lat_cnt_d;
         latency_q      <= latency_d;
         error_q        <= error_d;
         error_layer_q  <= error_layer_d;
         in_ready_q     <= in_ready_d;
         in_capture_q   <= in_capture_d;
         clear_q        <= clear_d;
         enable_q       <= enable_d;
         capture_q      <= capture_d;
         result_valid_q <= result_valid_d;
         busy_q         <= busy_d;
      end
   end

   assign inReady      = in_ready_q;
   assign inCapture    = in_capture_q;
   assign layerClear   = clear_q;
   assign layerEnable  = enable_q;
   assign layerCapture = capture_q;
   assign resultValid  = result_valid_q;
   assign busy         = busy_q;
   assign error        = error_q;
   assign errorLayer   = error_layer_q;
   assign latency      = latency_q;

endmodule

// File: tb/tb_network_sequencer.sv
// Scoreboard bench: dut_a uses the default watchdog, dut_b a short watchdog and a 4-bit latency
// counter. Stimulus pushes expected pulse events; a negedge monitor pops and compares them.
module tb_network_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   int         cyc = 0;

   logic       in_valid_a = 0, in_ready_a, in_capture_a, result_valid_a, result_ready_a = 0;
   logic       busy_a, error_a, err_clear_a = 0;
   logic [1:0] clear_a, enable_a, done_a = '0, lcap_a;
   logic [0:0] error_layer_a;
   logic [15:0] latency_a;

   logic       in_valid_b = 0, in_ready_b, in_capture_b, result_valid_b, result_ready_b = 0;
   logic       busy_b, error_b, err_clear_b = 0;
   logic [1:0] clear_b, enable_b, done_b = '0, lcap_b;
   logic [0:0] error_layer_b;
   logic [3:0] latency_b;

   network_sequencer #(.numLayers(2), .timeoutCycles(1024), .latencyWidth(16)) dut_a (
      .clk(clk), .reset(reset), .inValid(in_valid_a), .inReady(in_ready_a),
      .inCapture(in_capture_a), .layerClear(clear_a), .layerEnable(enable_a),
      .layerDone(done_a), .layerCapture(lcap_a), .resultValid(result_valid_a),
      .resultReady(result_ready_a), .busy(busy_a), .error(error_a),
      .errorLayer(error_layer_a), .errClear(err_clear_a), .latency(latency_a)
   );

   network_sequencer #(.numLayers(2), .timeoutCycles(8), .latencyWidth(4)) dut_b (
      .clk(clk), .reset(reset), .inValid(in_valid_b), .inReady(in_ready_b),
      .inCapture(in_capture_b), .layerClear(clear_b), .layerEnable(enable_b),
      .layerDone(done_b), .layerCapture(lcap_b), .resultValid(result_valid_b),
      .resultReady(result_ready_b), .busy(busy_b), .error(error_b),
      .errorLayer(error_layer_b), .errClear(err_clear_b), .latency(latency_b)
   );

   typedef struct {
      string name;
      int    cyc;
      int    val;
   } ev_t;

   ev_t sb_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic expect_ev(input string name, input int c, input int v);
      ev_t e;
      e.name = name;
      e.cyc  = c;
      e.val  = v;
      sb_q.push_back(e);
   endtask

   task automatic observe(input string name, input int v);
      ev_t e;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_errors++;
         $display("FAIL %s: unexpected event at cycle %0d value %0d", name, cyc, v);
      end else begin
         e = sb_q.pop_front();
         if (e.name != name || e.cyc != cyc || e.val != v) begin
            n_errors++;
            $display("FAIL %s: got %s at cycle %0d value %0d, expected %s at cycle %0d value %0d",
                     name, name, cyc, v, e.name, e.cyc, e.val);
         end
      end
   endtask

   // Pulse outputs and rising edges of resultValid / error are the scoreboard events.
   logic rv_prev_a = 0, er_prev_a = 0, rv_prev_b = 0, er_prev_b = 0;
   always @(negedge clk) begin
      if (!reset) begin
         if (in_capture_a) observe("a_in", 0);
         if (|clear_a) observe("a_clr", int'(clear_a));
         if (|lcap_a) observe("a_cap", int'(lcap_a));
         if (result_valid_a && !rv_prev_a) observe("a_res", int'(latency_a));
         if (error_a && !er_prev_a) observe("a_err", int'(error_layer_a));
         if (in_capture_b) observe("b_in", 0);
         if (|clear_b) observe("b_clr", int'(clear_b));
         if (|lcap_b) observe("b_cap", int'(lcap_b));
         if (result_valid_b && !rv_prev_b) observe("b_res", int'(latency_b));
         if (error_b && !er_prev_b) observe("b_err", int'(error_layer_b));
      end
      rv_prev_a <= result_valid_a;
      er_prev_a <= error_a;
      rv_prev_b <= result_valid_b;
      er_prev_b <= error_b;
   end

   task automatic step_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      int b;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_inready", int'(in_ready_a), 1);
      chk("rst_a_error", int'(error_a), 0);
      chk("rst_a_errlayer", int'(error_layer_a), 0);
      chk("rst_a_latency", int'(latency_a), 0);
      chk("rst_a_busy", int'(busy_a), 0);
      chk("rst_a_enable", int'(enable_a), 0);
      chk("rst_a_rvalid", int'(result_valid_a), 0);
      chk("rst_b_inready", int'(in_ready_b), 1);
      chk("rst_b_latency", int'(latency_b), 0);
      reset = 1'b0;
      step_to(cyc + 2);

      // Nominal two-layer inference, stray done on layer 1, slow consumer.
      b = cyc + 1;
      step_to(b);
      in_valid_a = 1;
      expect_ev("a_in", b + 1, 0);
      expect_ev("a_clr", b + 1, 1);
      expect_ev("a_clr", b + 21, 2);
      expect_ev("a_cap", b + 21, 1);
      expect_ev("a_cap", b + 36, 2);
      expect_ev("a_res", b + 36, 35);
      step_to(b + 1);
      in_valid_a = 0;
      chk("a_clear_enable", int'(enable_a), 0);
      chk("a_clear_busy", int'(busy_a), 1);
      chk("a_clear_inready", int'(in_ready_a), 0);
      step_to(b + 2);
      chk("a_run0_enable", int'(enable_a), 1);
      step_to(b + 10);
      done_a = 2'b10;
      step_to(b + 11);
      done_a = 2'b00;
      chk("a_stray_enable", int'(enable_a), 1);
      step_to(b + 20);
      chk("a_run0_last_enable", int'(enable_a), 1);
      done_a = 2'b01;
      step_to(b + 21);
      done_a = 2'b00;
      chk("a_cap0_enable", int'(enable_a), 0);
      step_to(b + 22);
      chk("a_run1_enable", int'(enable_a), 2);
      step_to(b + 35);
      chk("a_run1_last_enable", int'(enable_a), 2);
      done_a = 2'b10;
      step_to(b + 36);
      done_a = 2'b00;
      chk("a_done_enable", int'(enable_a), 0);
      chk("a_latency", int'(latency_a), 35);
      step_to(b + 40);
      in_valid_a = 1;
      step_to(b + 41);
      in_valid_a = 0;
      step_to(b + 45);
      chk("a_hold_rvalid", int'(result_valid_a), 1);
      chk("a_hold_inready", int'(in_ready_a), 0);
      step_to(b + 46);
      result_ready_a = 1;
      step_to(b + 47);
      result_ready_a = 0;
      chk("a_accept_inready", int'(in_ready_a), 1);
      chk("a_accept_rvalid", int'(result_valid_a), 0);
      chk("a_accept_busy", int'(busy_a), 0);
      step_to(b + 48);
      done_a = 2'b01;
      step_to(b + 49);
      done_a = 2'b00;
      step_to(b + 51);
      chk("a_idle_done_inready", int'(in_ready_a), 1);
      chk("a_idle_done_busy", int'(busy_a), 0);

      // Reset while layer 1 runs, then a clean inference.
      b = cyc + 1;
      step_to(b);
      in_valid_a = 1;
      expect_ev("a_in", b + 1, 0);
      expect_ev("a_clr", b + 1, 1);
      expect_ev("a_clr", b + 4, 2);
      expect_ev("a_cap", b + 4, 1);
      step_to(b + 1);
      in_valid_a = 0;
      step_to(b + 3);
      done_a = 2'b01;
      step_to(b + 4);
      done_a = 2'b00;
      step_to(b + 7);
      chk("a_prerst_enable", int'(enable_a), 2);
      reset = 1'b1;
      #1;
      chk("a_rst_enable", int'(enable_a), 0);
      chk("a_rst_inready", int'(in_ready_a), 1);
      chk("a_rst_busy", int'(busy_a), 0);
      chk("a_rst_latency", int'(latency_a), 0);
      step_to(b + 9);
      reset = 1'b0;
      b = cyc + 1;
      step_to(b);
      in_valid_a = 1;
      expect_ev("a_in", b + 1, 0);
      expect_ev("a_clr", b + 1, 1);
      expect_ev("a_clr", b + 5, 2);
      expect_ev("a_cap", b + 5, 1);
      expect_ev("a_cap", b + 9, 2);
      expect_ev("a_res", b + 9, 8);
      step_to(b + 1);
      in_valid_a = 0;
      step_to(b + 4);
      done_a = 2'b01;
      step_to(b + 5);
      done_a = 2'b00;
      step_to(b + 8);
      done_a = 2'b10;
      step_to(b + 9);
      done_a = 2'b00;
      chk("a_post_rst_latency", int'(latency_a), 8);
      result_ready_a = 1;
      step_to(b + 10);
      result_ready_a = 0;
      chk("a_post_rst_inready", int'(in_ready_a), 1);

      // dut_b: done on the exact limit cycle of each layer; latency saturates at 15.
      b = cyc + 1;
      step_to(b);
      in_valid_b = 1;
      expect_ev("b_in", b + 1, 0);
      expect_ev("b_clr", b + 1, 1);
      expect_ev("b_clr", b + 10, 2);
      expect_ev("b_cap", b + 10, 1);
      expect_ev("b_cap", b + 19, 2);
      expect_ev("b_res", b + 19, 15);
      step_to(b + 1);
      in_valid_b = 0;
      step_to(b + 9);
      done_b = 2'b01;
      step_to(b + 10);
      done_b = 2'b00;
      chk("b_edge0_error", int'(error_b), 0);
      step_to(b + 18);
      done_b = 2'b10;
      step_to(b + 19);
      done_b = 2'b00;
      chk("b_edge1_error", int'(error_b), 0);
      chk("b_sat_latency", int'(latency_b), 15);
      result_ready_b = 1;
      step_to(b + 20);
      result_ready_b = 0;
      chk("b_accept_inready", int'(in_ready_b), 1);

      // dut_b: layer 1 never completes.
      b = cyc + 1;
      step_to(b);
      in_valid_b = 1;
      expect_ev("b_in", b + 1, 0);
      expect_ev("b_clr", b + 1, 1);
      expect_ev("b_clr", b + 4, 2);
      expect_ev("b_cap", b + 4, 1);
      expect_ev("b_err", b + 13, 1);
      step_to(b + 1);
      in_valid_b = 0;
      step_to(b + 3);
      done_b = 2'b01;
      step_to(b + 4);
      done_b = 2'b00;
      step_to(b + 12);
      chk("b_last_run_enable", int'(enable_b), 2);
      chk("b_last_run_error", int'(error_b), 0);
      step_to(b + 13);
      chk("b_err_enable", int'(enable_b), 0);
      chk("b_err_busy", int'(busy_b), 0);
      chk("b_err_error", int'(error_b), 1);
      chk("b_err_layer", int'(error_layer_b), 1);
      chk("b_err_inready", int'(in_ready_b), 0);
      chk("b_err_latency_kept", int'(latency_b), 15);
      step_to(b + 15);
      chk("b_err_sticky", int'(error_b), 1);
      err_clear_b = 1;
      step_to(b + 16);
      err_clear_b = 0;
      chk("b_errclr_error", int'(error_b), 0);
      chk("b_errclr_inready", int'(in_ready_b), 1);
      chk("b_errclr_busy", int'(busy_b), 0);

      step_to(cyc + 3);
      chk("sb_drained", sb_q.size(), 0);
      while (sb_q.size() > 0) begin
         ev_t e;
         e = sb_q.pop_front();
         $display("FAIL %s: missing event, got none expected cycle %0d value %0d",
                  e.name, e.cyc, e.val);
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
